// File: rtl/clk_div2_div80_pair_if.sv
// Output bundle of the /2 and /80 clock-divider group.
// The divider drives through 'master'; downstream consumers attach through 'slave'.
interface clk_div2_div80_pair_if;
    logic out;
    logic div80;
    logic div80alt;
    logic mismatch;

    modport master (
        output out,
        output div80,
        output div80alt,
        output mismatch
    );

    modport slave (
        input out,
        input div80,
        input div80alt,
        input mismatch
    );
endinterface

// File: rtl/clk_div2_div80_pair.sv
// Fixed clock dividers: clk/2, plus two independently built clk/80 outputs
// (mod-40 counter and 8x5 cascade) with a sticky cross-check flag.
module clk_div2_div80_pair (
    input  logic                          clk,
    input  logic                          reset,
    clk_div2_div80_pair_if.master         div_o
);
    localparam int unsigned CW     = 6;
    localparam int unsigned C_LAST = 39;
    localparam int unsigned PW     = 3;
    localparam int unsigned P_LAST = 7;
    localparam int unsigned QW     = 3;
    localparam int unsigned Q_LAST = 4;

    logic          out_q,    out_d;
    logic          div80_q,  div80_d;
    logic          alt_q,    alt_d;
    logic          mm_q,     mm_d;
    logic [CW-1:0] c_q,      c_d;
    logic [PW-1:0] p_q,      p_d;
    logic [QW-1:0] q_q,      q_d;

    logic c_term;
    logic p_wrap;
    logic q_term;

    // Next-state logic; out-of-range c or q collapse back to 0 on their next step
    always_comb begin
        out_d   = ~out_q;

        c_term  = (c_q >= CW'(C_LAST));
        c_d     = c_term ? '0 : c_q + CW'(1);
        div80_d = div80_q ^ c_term;

        p_wrap  = (p_q == PW'(P_LAST));
        p_d     = p_q + PW'(1);

        q_term  = (q_q == QW'(Q_LAST));
        q_d     = q_q;
        if (p_wrap) begin
            q_d = (q_q >= QW'(Q_LAST)) ? '0 : q_q + QW'(1);
        end
        alt_d   = alt_q ^ (p_wrap & q_term);

        mm_d    = mm_q | (div80_q ^ alt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= 1'b0;
            div80_q <= 1'b0;
            alt_q   <= 1'b0;
            mm_q    <= 1'b0;
            c_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
        end else begin
            out_q   <= out_d;
            div80_q <= div80_d;
            alt_q   <= alt_d;
            mm_q    <= mm_d;
            c_q     <= c_d;
            p_q     <= p_d;
            q_q     <= q_d;
        end
    end

    assign div_o.out      = out_q;
    assign div_o.div80    = div80_q;
    assign div_o.div80alt = alt_q;
    assign div_o.mismatch = mm_q;
endmodule

// File: tb/tb_clk_div2_div80_pair.sv
// Bench for clk_div2_div80_pair: checkpoint table, per-cycle reference model,
// randomized reset/run phases, duty measurement and an illegal-state recovery sequence.
module tb_clk_div2_div80_pair;
    logic clk;
    logic reset;

    clk_div2_div80_pair_if div_if ();

    clk_div2_div80_pair dut (
        .clk   (clk),
        .reset (reset),
        .div_o (div_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    typedef struct {
        int n;
        bit exp_out;
        bit exp_div;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d got=%b expected=%b t=%0t", name, n, act, exp, $time);
        end
    endtask

    // Reference: after n edges out is n mod 2, each /80 output is floor(n/40) mod 2
    task automatic check_model();
        bit eo;
        bit ed;
        eo = (n % 2) == 1;
        ed = ((n / 40) % 2) == 1;
        chk("out",      div_if.out,      eo);
        chk("div80",    div_if.div80,    ed);
        chk("div80alt", div_if.div80alt, ed);
        chk("mismatch", div_if.mismatch, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out"},      div_if.out,      1'b0);
        chk({tag, "_div80"},    div_if.div80,    1'b0);
        chk({tag, "_div80alt"}, div_if.div80alt, 1'b0);
        chk({tag, "_mismatch"}, div_if.mismatch, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_checked(input int k);
        for (int i = 0; i < k; i++) begin
            step();
            check_model();
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        for (int i = 0; i < cycles; i++) begin
            step();
            check_zero("rst_hold");
        end
        reset = 1'b0;
        n = 0;
    endtask

    initial begin
        int  run_len;
        logic last_d, last_a, last_o;
        int  len_d, len_a, len_o;
        bit  seen_d, seen_a;

        tbl[0]  = '{1,   1'b1, 1'b0};
        tbl[1]  = '{2,   1'b0, 1'b0};
        tbl[2]  = '{39,  1'b1, 1'b0};
        tbl[3]  = '{40,  1'b0, 1'b1};
        tbl[4]  = '{41,  1'b1, 1'b1};
        tbl[5]  = '{79,  1'b1, 1'b1};
        tbl[6]  = '{80,  1'b0, 1'b0};
        tbl[7]  = '{81,  1'b1, 1'b0};
        tbl[8]  = '{119, 1'b1, 1'b0};
        tbl[9]  = '{120, 1'b0, 1'b1};
        tbl[10] = '{159, 1'b1, 1'b1};
        tbl[11] = '{160, 1'b0, 1'b0};

        reset = 1'b0;
        #2;
        // Reset held for 5 clocks: all outputs stay low
        do_reset(5);

        // Checkpoint table over the first 160 edges
        for (int i = 0; i < 12; i++) begin
            while (n < tbl[i].n) step();
            chk("tbl_out",      div_if.out,      tbl[i].exp_out);
            chk("tbl_div80",    div_if.div80,    tbl[i].exp_div);
            chk("tbl_div80alt", div_if.div80alt, tbl[i].exp_div);
            chk("tbl_mismatch", div_if.mismatch, 1'b0);
        end

        // Full 200-edge run compared every cycle
        do_reset(1);
        run_checked(200);

        // Asynchronous reset between edges after n=57
        do_reset(2);
        run_checked(57);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid57");
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        run_checked(45);

        // Randomized reset lengths, run lengths and reset phases
        for (int it = 0; it < 6; it++) begin
            do_reset(int'($urandom_range(1, 4)));
            run_len = int'($urandom_range(30, 300));
            run_checked(run_len);
            #($urandom_range(1, 3));
            reset = 1'b1;
            #1;
            check_zero("rand_async");
            @(negedge clk);
            reset = 1'b0;
            n = 0;
            run_checked(3);
        end

        // 1000 edges: measure high/low run lengths
        do_reset(1);
        last_d = div_if.div80; last_a = div_if.div80alt; last_o = div_if.out;
        len_d = 1; len_a = 1; len_o = 1;
        seen_d = 1'b0; seen_a = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (div_if.div80 !== last_d) begin
                if (seen_d) begin
                    checks++;
                    if (len_d != 40) begin
                        failures++;
                        $display("FAIL div80_run n=%0d got=%0d expected=40", n, len_d);
                    end
                end
                seen_d = 1'b1; len_d = 1; last_d = div_if.div80;
            end else len_d++;
            if (div_if.div80alt !== last_a) begin
                if (seen_a) begin
                    checks++;
                    if (len_a != 40) begin
                        failures++;
                        $display("FAIL div80alt_run n=%0d got=%0d expected=40", n, len_a);
                    end
                end
                seen_a = 1'b1; len_a = 1; last_a = div_if.div80alt;
            end else len_a++;
            checks++;
            if (div_if.out === last_o || len_o != 1) begin
                failures++;
                $display("FAIL out_period n=%0d got=%b prev=%b", n, div_if.out, last_o);
            end
            last_o = div_if.out;
        end
        chk("duty_mismatch", div_if.mismatch, 1'b0);

        // Illegal q forced mid-count: returns to 0 at the next p==7 edge, then outputs diverge
        do_reset(1);
        run_checked(5);
        force dut.q_q = 3'd6;
        #1;
        release dut.q_q;
        step();
        chk("q_hold6", dut.q_q == 3'd6, 1'b1);
        step();
        chk("q_hold7", dut.q_q == 3'd6, 1'b1);
        step();
        chk("q_recover", dut.q_q == 3'd0, 1'b1);
        while (n < 40) step();
        chk("frc_div80",    div_if.div80,    1'b1);
        chk("frc_div80alt", div_if.div80alt, 1'b0);
        chk("frc_mm_pre",   div_if.mismatch, 1'b0);
        step();
        chk("frc_mm_set",   div_if.mismatch, 1'b1);
        while (n < 48) step();
        chk("frc_alt_late", div_if.div80alt, 1'b1);
        step();
        chk("frc_mm_sticky", div_if.mismatch, 1'b1);
        do_reset(1);
        step();
        chk("frc_mm_clear", div_if.mismatch, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
